// File: rtl/btn_pkg.sv
// btn_pkg: shared state encodings and defaults for the board-input conditioners.
package btn_pkg;
  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;
  localparam int DEBOUNCE_DEFAULT = 250000;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/sync2.sv
// sync2: generic two-flop synchronizer with async active-low reset.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] m;
  always_ff @(posedge clk or negedge rst)
    if (!rst) {q, m} <= '0;
    else {q, m} <= {m, d};
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounced level plus press/release pulses from a raw button.
// Optional auto-repeat on held buttons when BTN_AUTOREPEAT_EN is defined.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = 18,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
  logic s2, level_d, press_d, release_d, tick;
  sync2 #(.W(1)) u_sync (.clk(clk), .rst(rst), .d(btn_in), .q(s2));
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    level_d   = btn_level;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state)
      ST_IDLE:
        if (s2) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      ST_PRESS_WAIT:
        if (!s2) state_d = ST_IDLE;
        else if (cnt == LAST) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else cnt_d = cnt_inc;
      ST_PRESSED:
        if (!s2) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end
      default:
        if (s2) state_d = ST_PRESSED;
        else if (cnt == LAST) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else cnt_d = cnt_inc;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      btn_level   <= level_d;
      btn_press   <= press_d | tick;
      btn_release <= release_d;
    end
`ifdef BTN_AUTOREPEAT_EN
  localparam int REP_W = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  logic [REP_W-1:0] rep, rep_d, rep_lim;
  logic phase, phase_d;
  // phase=0 waits out the initial delay, phase=1 counts repeat periods
  always_comb begin
    rep_lim = phase ? REP_W'(REPEAT_PERIOD - 1) : REP_W'(REPEAT_DELAY - 1);
    tick    = state == ST_PRESSED && s2 && rep == rep_lim;
    rep_d   = state_d == ST_IDLE ? '0 : (state == ST_PRESSED && s2) ? (tick ? '0 : rep + 1'b1) : rep;
    phase_d = state_d != ST_IDLE && (phase || tick);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rep   <= '0;
      phase <= 1'b0;
    end else begin
      rep   <= rep_d;
      phase <= phase_d;
    end
`else
  assign tick = 1'b0;
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
  end
`endif
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: run-length reference model plus directed button scenarios.
module tb_button_conditioner;
  localparam int N = 4, RD = 10, RP = 3;
  logic clk = 1'b0, rst = 1'b0, btn_in = 1'b0;
  logic btn_level, btn_press, btn_release;
  int n_assert = 0, n_fail = 0, n_press = 0, n_rel = 0;
  bit q1, q2, s, lvl, ep, er;
  int run, held;

  button_conditioner #(.DEBOUNCE_CYCLES(N), .CNT_W(4), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // A change is accepted once the synchronized input has disagreed with the
  // level for N+1 consecutive samples; any agreeing sample clears the run.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q1 = 0; q2 = 0; lvl = 0; ep = 0; er = 0; run = 0; held = 0;
    end else begin
      s = q2; q2 = q1; q1 = btn_in;
      ep = 0; er = 0;
      if (s != lvl) begin
        run++;
        if (run == N + 1) begin
          lvl = s; run = 0; held = 0;
          if (s) ep = 1; else er = 1;
        end
      end else begin
`ifdef BTN_AUTOREPEAT_EN
        if (lvl && run == 0) begin
          held++;
          ep = (held == RD) || (held > RD && (held - RD) % RP == 0);
        end
`endif
        run = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("level", btn_level, lvl);
    chk("press", btn_press, ep);
    chk("release", btn_release, er);
    chk("press_release_exclusive", btn_press & btn_release, 0);
    n_press += int'(btn_press);
    n_rel += int'(btn_release);
  end

  initial begin
    int p, r;
    btn_in = 1; rst = 0;
    step(3);
    chk("rst_level", btn_level, 0);
    chk("rst_press", btn_press, 0);
    chk("rst_release", btn_release, 0);
    rst = 1;
    for (int j = 1; j <= 8; j++) begin
      step(1);
      chk("lat_press", btn_press, int'(j == 7));
      chk("lat_level", btn_level, int'(j >= 7));
    end
    btn_in = 0;
    step(12);
    p = n_press;
    repeat (5) begin
      btn_in = 1; step(3);
      btn_in = 0; step(1);
    end
    step(10);
    chk("bounce_press", n_press - p, 0);
    chk("bounce_level", btn_level, 0);
    p = n_press; r = n_rel;
    btn_in = 1; step(20);
    btn_in = 0;
    for (int j = 1; j <= 8; j++) begin
      step(1);
      chk("rel_pulse", btn_release, int'(j == 7));
      chk("rel_level", btn_level, int'(j < 7));
    end
    step(4);
`ifdef BTN_AUTOREPEAT_EN
    chk("clean_press", n_press - p, 3);
`else
    chk("clean_press", n_press - p, 1);
`endif
    chk("clean_rel", n_rel - r, 1);
    p = n_press; r = n_rel;
    btn_in = 1; step(12);
    btn_in = 0; step(2);
    btn_in = 1; step(10);
    chk("relbounce_level", btn_level, 1);
    chk("relbounce_rel", n_rel - r, 0);
`ifndef BTN_AUTOREPEAT_EN
    chk("relbounce_press", n_press - p, 1);
`endif
    btn_in = 0; step(12);
    chk("relbounce_end", btn_level, 0);
    btn_in = 1; step(4);
    rst = 0; #1;
    chk("rstpw_level", btn_level, 0);
    chk("rstpw_press", btn_press, 0);
    step(2);
    p = n_press;
    rst = 1; step(10);
    chk("rstpw_relevel", btn_level, 1);
    chk("rstpw_repress", n_press - p, 1);
    r = n_rel;
    rst = 0; #1;
    chk("rstp_level", btn_level, 0);
    chk("rstp_release", btn_release, 0);
    step(3);
    chk("rstp_hold_level", btn_level, 0);
    p = n_press;
    rst = 1; step(10);
    chk("rstp_relevel", btn_level, 1);
    chk("rstp_repress", n_press - p, 1);
    chk("rstp_norel", n_rel - r, 0);
    btn_in = 0; step(12);
    chk("rstp_end", btn_level, 0);
`ifdef BTN_AUTOREPEAT_EN
    p = n_press;
    btn_in = 1; step(40);
    btn_in = 0; step(12);
    chk("rep_count", n_press - p, 10);
    chk("rep_level", btn_level, 0);
    p = n_press;
    step(20);
    chk("rep_after_release", n_press - p, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
